router_ctrl: RTL and testbench

Packet controller for the 1x3 router. It decodes each incoming packet header and sequences writes of header, payload and parity into one of three output FIFOs. It stalls the source on FIFO full and checks parity. A per-port watchdog issues a soft reset to any FIFO whose data sits unread too long. It sits between the router input port and the three `router_fifo` instances, driving their `write_enb`, `lfd_state` and `soft_reset`.

---
 rtl/router_pkg.sv | 32 +++
 rtl/router_sreset_timer.sv | 30 +++
 rtl/router_ctrl.sv | 152 +++++++++++++++
 tb/tb_router_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
// Header layout: [7:2] payload length, [1:0] destination port.
package router_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_EMPTY,
      ST_LOAD_HDR,
      ST_LOAD_DATA,
      ST_LOAD_PARITY,
      ST_CHECK,
      ST_DROP
   } state_t;

   localparam logic [1:0] ADDR_INVALID = 2'b11;
   localparam int         NUM_PORTS    = 3;
   localparam int         LEN_MSB      = 7;
   localparam int         LEN_LSB      = 2;
   localparam int         ADDR_MSB     = 1;
   localparam int         ADDR_LSB     = 0;

   // One-hot port select; the invalid address selects nothing.
   function automatic logic [NUM_PORTS-1:0] port_mask(input logic [1:0] addr);
      case (addr)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/router_sreset_timer.sv
// Per-port watchdog: counts cycles of unread data and pulses soft_reset after TIMEOUT cycles.
// The pulse is combinational from the count; the count clears on a read, an empty FIFO or the pulse.
module router_sreset_timer #(
   parameter int TIMEOUT = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic vld,
   input  logic read_enb,
   input  logic empty,
   output logic soft_reset
);

   localparam logic [4:0] LAST = 5'(TIMEOUT - 1);

   logic [4:0] cnt;

   assign soft_reset = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (read_enb || empty || soft_reset) begin
         cnt <= '0;
      end else if (vld) begin
         cnt <= cnt + 5'd1;
      end
   end

endmodule

// File: rtl/router_ctrl.sv
// Router packet controller: decodes headers and steers header/payload/parity writes into one of three FIFOs.
// Header write one cycle after header accept, then 1 byte/cycle; busy stalls the source on target-FIFO full.
module router_ctrl
   import router_pkg::*;
#(
   parameter int TIMEOUT = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pkt_valid,
   input  logic [7:0]           data_in,
   input  logic [NUM_PORTS-1:0] fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] read_enb,
   output logic                 busy,
   output logic [NUM_PORTS-1:0] write_enb,
   output logic                 lfd_state,
   output logic [7:0]           data_to_fifo,
   output logic [NUM_PORTS-1:0] vld_out,
   output logic [NUM_PORTS-1:0] soft_reset,
   output logic                 err
);

   state_t               state, state_n;
   logic [7:0]           hdr_q, hdr_n, par_q, par_n;
   logic [5:0]           rem_q, rem_n;
   logic                 err_q, err_n;
   logic [NUM_PORTS-1:0] tgt;
   logic                 tgt_full, tgt_empty, tgt_sreset;

   assign tgt        = port_mask(hdr_q[ADDR_MSB:ADDR_LSB]);
   assign tgt_full   = |(fifo_full & tgt);
   assign tgt_empty  = |(fifo_empty & tgt);
   assign tgt_sreset = |(soft_reset & tgt);

   assign vld_out      = ~fifo_empty;
   assign err          = err_q;
   assign data_to_fifo = reset ? 8'h00 : ((state == ST_LOAD_HDR) ? hdr_q : data_in);

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wd
      router_sreset_timer #(.TIMEOUT(TIMEOUT)) u_timer (
         .clk        (clk),
         .reset      (reset),
         .vld        (vld_out[i]),
         .read_enb   (read_enb[i]),
         .empty      (fifo_empty[i]),
         .soft_reset (soft_reset[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         hdr_q <= '0;
         par_q <= '0;
         rem_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         hdr_q <= hdr_n;
         par_q <= par_n;
         rem_q <= rem_n;
         err_q <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      hdr_n     = hdr_q;
      par_n     = par_q;
      rem_n     = rem_q;
      err_n     = err_q;
      busy      = 1'b0;
      write_enb = '0;
      lfd_state = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pkt_valid) begin
               hdr_n = data_in;
               par_n = data_in;
               rem_n = data_in[LEN_MSB:LEN_LSB];
               err_n = 1'b0;
               if (data_in[ADDR_MSB:ADDR_LSB] == ADDR_INVALID) begin
                  state_n = ST_DROP;
                  err_n   = 1'b1;
               end else if (|(fifo_empty & port_mask(data_in[ADDR_MSB:ADDR_LSB]))) begin
                  state_n = ST_LOAD_HDR;
               end else begin
                  state_n = ST_WAIT_EMPTY;
               end
            end
         end
         ST_WAIT_EMPTY: begin
            busy = 1'b1;
            if (tgt_sreset) begin
               state_n = ST_DROP;
               err_n   = 1'b1;
            end else if (tgt_empty) begin
               state_n = ST_LOAD_HDR;
            end
         end
         ST_LOAD_HDR: begin
            busy      = 1'b1;
            lfd_state = 1'b1;
            if (tgt_sreset) begin
               state_n = ST_DROP;
               err_n   = 1'b1;
            end else if (!tgt_full) begin
               write_enb = tgt;
               state_n   = (rem_q == 6'd0) ? ST_LOAD_PARITY : ST_LOAD_DATA;
            end
         end
         ST_LOAD_DATA: begin
            busy = tgt_full;
            if (pkt_valid && !tgt_full) begin
               rem_n = rem_q - 6'd1;
               par_n = par_q ^ data_in;
               if (!tgt_sreset) write_enb = tgt;
               if (rem_q == 6'd1) state_n = ST_LOAD_PARITY;
            end
            // A flushed FIFO abandons the packet; DROP eats whatever is still owed.
            if (tgt_sreset) begin
               state_n = ST_DROP;
               err_n   = 1'b1;
            end
         end
         ST_LOAD_PARITY: begin
            busy = tgt_full;
            if (tgt_sreset) begin
               err_n   = 1'b1;
               state_n = (pkt_valid && !tgt_full) ? ST_IDLE : ST_DROP;
            end else if (pkt_valid && !tgt_full) begin
               write_enb = tgt;
               err_n     = (data_in != par_q);
               state_n   = ST_CHECK;
            end
         end
         ST_CHECK: begin
            busy    = 1'b1;
            state_n = ST_IDLE;
         end
         ST_DROP: begin
            if (pkt_valid) begin
               if (rem_q == 6'd0) state_n = ST_IDLE;
               else               rem_n   = rem_q - 6'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_router_ctrl.sv
// Scoreboard bench for router_ctrl: expected FIFO writes are queued per packet and popped by a monitor.
module tb_router_ctrl;

   localparam int TIMEOUT = 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full, fifo_empty, read_enb;
   logic       busy, lfd_state, err;
   logic [2:0] write_enb, vld_out, soft_reset;
   logic [7:0] data_to_fifo;

   typedef struct packed {
      logic [1:0] port;
      logic       lfd;
      logic [7:0] dat;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] pl_q[$];
   int         total = 0;
   int         bad = 0;
   int         wr_cnt = 0;
   int         busy_cycles, pkt_busy, pay_busy, force_full;
   logic [2:0] force_mask;
   logic       rand_full;
   logic [1:0] mon_p;
   wr_t        mon_got, mon_exp;

   router_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .pkt_valid    (pkt_valid),
      .data_in      (data_in),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .read_enb     (read_enb),
      .busy         (busy),
      .write_enb    (write_enb),
      .lfd_state    (lfd_state),
      .data_to_fifo (data_to_fifo),
      .vld_out      (vld_out),
      .soft_reset   (soft_reset),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic wr_t mk(input logic [1:0] p, input logic l, input logic [7:0] d);
      wr_t r;
      r.port = p;
      r.lfd  = l;
      r.dat  = d;
      return r;
   endfunction

   // Monitor: every FIFO write must be the next expected byte for the right port.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!reset && write_enb != 3'b000) begin
            mon_p = 2'd0;
            for (int i = 0; i < 3; i++) if (write_enb[i]) mon_p = 2'(i);
            check("wr_onehot", 32'($onehot(write_enb)), 1);
            check("wr_while_full", 32'(write_enb & fifo_full), 0);
            wr_cnt++;
            mon_got = mk(mon_p, lfd_state, data_to_fifo);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wr_unexpected: got port=%0d dat=%0h want=no write", mon_p, data_to_fifo);
            end else begin
               mon_exp = exp_q.pop_front();
               check("wr_data", 32'(mon_got), 32'(mon_exp));
            end
         end
      end
   end

   // Presents one byte and holds it until a cycle with busy low accepts it.
   task automatic put_byte(input logic [7:0] b);
      int   guard;
      logic took;
      guard = 0;
      took  = 1'b0;
      pkt_valid = 1'b1;
      data_in   = b;
      while (!took && guard < 200) begin
         if (force_full > 0) fifo_full = force_mask;
         else if (rand_full) for (int i = 0; i < 3; i++) fifo_full[i] = ($urandom_range(0, 4) == 0);
         else fifo_full = 3'b000;
         #1;
         if (busy) busy_cycles++;
         if (force_full > 0) begin
            check("busy_on_full", 32'(busy), 1);
            force_full--;
         end
         took = !busy;
         @(negedge clk);
         guard++;
      end
      if (!took) begin
         total++;
         bad++;
         $display("FAIL consume_timeout: byte %0h not accepted within 200 cycles", b);
      end
   endtask

   // Sends header, pl_q payload and parity; expected writes and err come from the packet rules.
   task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par, input int stall_at,
                              input bit chk_timing);
      logic [7:0] x;
      logic       exp_err;
      int         first_busy;
      x = hdr;
      foreach (pl_q[i]) x ^= pl_q[i];
      exp_err = (hdr[1:0] == 2'b11) || (par != x);
      if (hdr[1:0] != 2'b11) begin
         exp_q.push_back(mk(hdr[1:0], 1'b1, hdr));
         foreach (pl_q[i]) exp_q.push_back(mk(hdr[1:0], 1'b0, pl_q[i]));
         exp_q.push_back(mk(hdr[1:0], 1'b0, par));
      end
      busy_cycles = 0;
      put_byte(hdr);
      if (chk_timing) begin
         check("hdr_lfd_t1", 32'(lfd_state), 1);
         check("hdr_wr_t1", 32'(write_enb), 32'(3'b001 << hdr[1:0]));
         check("hdr_dat_t1", 32'(data_to_fifo), 32'(hdr));
         check("hdr_busy_t1", 32'(busy), 1);
      end
      first_busy = busy_cycles;
      foreach (pl_q[i]) begin
         if (i == stall_at) begin
            force_full = 4;
            force_mask = 3'b001 << hdr[1:0];
         end
         put_byte(pl_q[i]);
         if (i == 0) first_busy = busy_cycles;
      end
      put_byte(par);
      pkt_busy = busy_cycles;
      pay_busy = busy_cycles - first_busy;
      check("err", 32'(err), 32'(exp_err));
      pkt_valid = 1'b0;
      fifo_full = 3'b000;
      @(negedge clk);
   endtask

   // Port 2 holds unread data; the pulse is due TIMEOUT cycles after the last read or pulse.
   task automatic watchdog_run(input int read_cycle);
      int   start, seen, want;
      logic exp_p;
      start = 1;
      seen  = 0;
      want  = 0;
      fifo_empty = 3'b011;
      for (int c = 1; c <= 36; c++) begin
         read_enb = 3'b000;
         exp_p = (c - start + 1 == TIMEOUT);
         check("sreset2", 32'(soft_reset[2]), 32'(exp_p));
         check("sreset_others", 32'(soft_reset[1:0]), 0);
         if (soft_reset[2]) seen++;
         if (exp_p) begin
            want++;
            start = c + 1;
         end
         if (c == read_cycle) begin
            read_enb = 3'b100;
            start    = c + 1;
         end
         @(negedge clk);
      end
      check("sreset_pulses", 32'(seen), 32'(want));
      read_enb   = 3'b000;
      fifo_empty = 3'b111;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int         w0;
      int         len;
      logic [1:0] addr;
      logic [7:0] hdr, x;
      reset      = 1'b1;
      pkt_valid  = 1'b0;
      data_in    = 8'hA5;
      fifo_full  = 3'b000;
      fifo_empty = 3'b101;
      read_enb   = 3'b000;
      rand_full  = 1'b0;
      force_full = 0;
      force_mask = 3'b000;
      #2;
      check("rst_busy", 32'(busy), 0);
      check("rst_wr", 32'(write_enb), 0);
      check("rst_lfd", 32'(lfd_state), 0);
      check("rst_sreset", 32'(soft_reset), 0);
      check("rst_err", 32'(err), 0);
      check("rst_dat", 32'(data_to_fifo), 0);
      check("rst_vld_out", 32'(vld_out), 32'(3'b010));
      fifo_empty = 3'b111;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Good packet to port 1, then the same packet with a wrong parity byte.
      pl_q = '{8'h11, 8'h22, 8'h33};
      w0 = wr_cnt;
      send_packet(8'h0D, 8'h0D, -1, 1'b1);
      check("pkt1_writes", 32'(wr_cnt - w0), 5);
      w0 = wr_cnt;
      send_packet(8'h0D, 8'h00, -1, 1'b1);
      check("pkt2_writes", 32'(wr_cnt - w0), 5);

      // Invalid address with L=0: one trailing byte is dropped.
      pl_q.delete();
      w0 = wr_cnt;
      send_packet(8'h03, 8'h5A, -1, 1'b0);
      check("drop_writes", 32'(wr_cnt - w0), 0);
      check("drop_busy", 32'(pkt_busy), 0);
      check("drop_idle_busy", 32'(busy), 0);

      // Target FIFO still holding data: header waits for empty.
      pl_q = '{8'h9C, 8'h47};
      fifo_empty = 3'b011;
      w0 = wr_cnt;
      fork
         send_packet({6'd2, 2'd2}, 8'h9C ^ 8'h47 ^ {6'd2, 2'd2}, -1, 1'b0);
         begin
            repeat (4) @(negedge clk);
            #1;
            check("wait_empty_nowr", 32'(wr_cnt - w0), 0);
            check("wait_empty_busy", 32'(busy), 1);
            fifo_empty = 3'b111;
         end
      join
      check("wait_pkt_writes", 32'(wr_cnt - w0), 4);

      // L=20 to port 0 with the FIFO full for 4 cycles mid-payload.
      pl_q.delete();
      for (int i = 0; i < 20; i++) pl_q.push_back(8'($urandom));
      x = {6'd20, 2'd0};
      foreach (pl_q[i]) x ^= pl_q[i];
      w0 = wr_cnt;
      send_packet({6'd20, 2'd0}, x, 10, 1'b1);
      check("stall_busy_cycles", 32'(pay_busy), 4);
      check("stall_writes", 32'(wr_cnt - w0), 22);

      // Random packets with random full back-pressure.
      rand_full = 1'b1;
      for (int n = 0; n < 30; n++) begin
         len  = $urandom_range(0, 15);
         addr = 2'($urandom_range(0, 3));
         hdr  = {6'(len), addr};
         pl_q.delete();
         for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
         x = hdr;
         foreach (pl_q[i]) x ^= pl_q[i];
         if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
         send_packet(hdr, x, -1, 1'b0);
      end
      rand_full = 1'b0;

      watchdog_run(0);
      watchdog_run(15);

      // Reset in the middle of a payload.
      exp_q.push_back(mk(2'd0, 1'b1, {6'd10, 2'd0}));
      put_byte({6'd10, 2'd0});
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk(2'd0, 1'b0, 8'(8'h60 + i)));
         put_byte(8'(8'h60 + i));
      end
      data_in = 8'hC3;
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_wr", 32'(write_enb), 0);
      check("mid_rst_lfd", 32'(lfd_state), 0);
      check("mid_rst_dat", 32'(data_to_fifo), 0);
      check("mid_rst_err", 32'(err), 0);
      check("mid_rst_sreset", 32'(soft_reset), 0);
      pkt_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_pending", 32'(exp_q.size()), 0);
      exp_q.delete();
      @(negedge clk);
      pl_q = '{8'hF0};
      w0 = wr_cnt;
      send_packet({6'd1, 2'd1}, 8'hF0 ^ {6'd1, 2'd1}, -1, 1'b1);
      check("post_rst_writes", 32'(wr_cnt - w0), 3);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
